// File: rtl/muldiv_if.sv
// Handshake and datapath bundle between the EX stage, the external multiplier
// and the M-extension sequencer.
interface muldiv_if;
   logic        op_valid;
   logic [2:0]  md_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        load_hazard;
   logic        flush;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic [1:0]  mult_sel;
   logic        mult_ce;
   logic [63:0] mult_p;
   logic        stall;
   logic [31:0] res;
   logic        res_valid;

   modport master (
      output op_valid, md_op, op_a, op_b, load_hazard, flush, mult_p,
      input  mult_a, mult_b, mult_sel, mult_ce, stall, res, res_valid
   );

   modport slave (
      input  op_valid, md_op, op_a, op_b, load_hazard, flush, mult_p,
      output mult_a, mult_b, mult_sel, mult_ce, stall, res, res_valid
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32 M-extension sequencer: drives an external pipelined multiplier and runs
// a 32-step restoring divider, holding the pipeline while either is busy.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for an op; accept happens here
// MUL_WAIT | multiplier enabled for MUL_LAT+1 cycles, operands held
// DIV_RUN  | one quotient bit per cycle, 32 cycles
// DONE     | res_valid; held here while load_hazard is set
module muldiv_ctrl #(
   parameter int unsigned MUL_LAT = 1
) (
   input  logic     CLK,
   input  logic     nrst,
   muldiv_if.slave  bus
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_MUL_WAIT = 2'd1;
   localparam logic [1:0] S_DIV_RUN  = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
   localparam logic [5:0] DIV_CNT = 6'd31;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [2:0]  op_q;
   logic        neg_q;
   logic        neg_r;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] dvs;

   logic        accept;
   logic        is_div;
   logic        is_sdiv;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] special_res;
   logic [1:0]  sel_map;
   logic [32:0] r_sh;
   logic [33:0] diff;
   logic        fits;
   logic [31:0] quo_nxt;
   logic [31:0] rem_nxt;
   logic [31:0] div_res;
   logic [31:0] mul_res;

   always_comb begin
      accept   = (state == S_IDLE) & bus.op_valid & ~bus.load_hazard & ~bus.flush;
      is_div   = bus.md_op[2];
      is_sdiv  = is_div & ~bus.md_op[0];
      div_zero = (bus.op_b == 32'd0);
      div_ovf  = is_sdiv & (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
      abs_a    = (is_sdiv & bus.op_a[31]) ? -bus.op_a : bus.op_a;
      abs_b    = (is_sdiv & bus.op_b[31]) ? -bus.op_b : bus.op_b;

      // Divide-by-zero wins over overflow; bit 1 of funct3 selects remainder.
      if (div_zero)
         special_res = bus.md_op[1] ? bus.op_a : 32'hFFFF_FFFF;
      else
         special_res = bus.md_op[1] ? 32'd0 : 32'h8000_0000;

      case (bus.md_op[1:0])
         2'd1:    sel_map = 2'd0;
         2'd2:    sel_map = 2'd1;
         default: sel_map = 2'd2;
      endcase
   end

   // One restoring step: the partial remainder stays below the divisor, so
   // the shifted value fits in 33 bits and the difference sign is bit 33.
   always_comb begin
      r_sh    = {rem, quo[31]};
      diff    = {1'b0, r_sh} - {2'b00, dvs};
      fits    = ~diff[33];
      quo_nxt = {quo[30:0], fits};
      rem_nxt = fits ? diff[31:0] : r_sh[31:0];
      if (op_q[1])
         div_res = neg_r ? -rem_nxt : rem_nxt;
      else
         div_res = neg_q ? -quo_nxt : quo_nxt;
      mul_res = (op_q == 3'd0) ? bus.mult_p[31:0] : bus.mult_p[63:32];
   end

   assign bus.stall     = accept | (state == S_MUL_WAIT) | (state == S_DIV_RUN);
   assign bus.mult_ce   = (state == S_MUL_WAIT);
   assign bus.res_valid = (state == S_DONE);

   always_ff @(posedge CLK) begin
      if (!nrst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         op_q         <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         quo          <= '0;
         rem          <= '0;
         dvs          <= '0;
         bus.res      <= '0;
         bus.mult_a   <= '0;
         bus.mult_b   <= '0;
         bus.mult_sel <= '0;
      end else if (bus.flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q <= bus.md_op;
                  if (!is_div) begin
                     bus.mult_a   <= bus.op_a;
                     bus.mult_b   <= bus.op_b;
                     bus.mult_sel <= sel_map;
                     cnt          <= MUL_CNT;
                     state        <= S_MUL_WAIT;
                  end else if (div_zero | div_ovf) begin
                     bus.res <= special_res;
                     state   <= S_DONE;
                  end else begin
                     quo   <= abs_a;
                     rem   <= '0;
                     dvs   <= abs_b;
                     neg_q <= is_sdiv & (bus.op_a[31] ^ bus.op_b[31]);
                     neg_r <= is_sdiv & bus.op_a[31];
                     cnt   <= DIV_CNT;
                     state <= S_DIV_RUN;
                  end
               end
            end
            S_MUL_WAIT: begin
               if (cnt == 6'd0) begin
                  bus.res <= mul_res;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            S_DIV_RUN: begin
               quo <= quo_nxt;
               rem <= rem_nxt;
               if (cnt == 6'd0) begin
                  bus.res <= div_res;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            default: begin
               if (!bus.load_hazard)
                  state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural pipelined multiplier.
module tb_muldiv_ctrl;
   localparam int MUL_LAT = 1;

   logic CLK = 1'b0;
   logic nrst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   muldiv_if bus ();

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .CLK  (CLK),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] sel);
      logic [63:0] sa, sb, ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'd0, b};
      case (sel)
         2'd0:    return sa * sb;
         2'd1:    return sa * ub;
         default: return {32'd0, a} * ub;
      endcase
   endfunction

   logic [63:0] mpipe [MUL_LAT];
   always @(posedge CLK) begin
      if (bus.mult_ce) begin
         mpipe[0] <= mul_model(bus.mult_a, bus.mult_b, bus.mult_sel);
         for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
      end
   end
   assign bus.mult_p = mpipe[MUL_LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Presents one op from IDLE, counts stall and mult_ce cycles, then checks
   // the DONE cycle and the return to IDLE.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_stall, input int exp_ce);
      int n, nce;
      n = 0;
      nce = 0;
      bus.op_valid = 1'b1;
      bus.md_op    = op;
      bus.op_a     = a;
      bus.op_b     = b;
      #1;
      while (bus.stall && n < 100) begin
         n++;
         if (bus.mult_ce) nce++;
         @(posedge CLK);
         #1;
         bus.op_valid = 1'b0;
         #1;
      end
      bus.op_valid = 1'b0;
      chk({tag, " stall_cycles"}, 64'(n), 64'(exp_stall));
      chk({tag, " ce_cycles"}, 64'(nce), 64'(exp_ce));
      chk({tag, " res_valid"}, 64'(bus.res_valid), 64'd1);
      chk({tag, " res"}, 64'(bus.res), 64'(exp_res));
      cyc();
      chk({tag, " res_valid_drop"}, 64'(bus.res_valid), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " res"}, 64'(bus.res), 64'd0);
      chk({tag, " mult_a"}, 64'(bus.mult_a), 64'd0);
      chk({tag, " mult_b"}, 64'(bus.mult_b), 64'd0);
      chk({tag, " mult_sel"}, 64'(bus.mult_sel), 64'd0);
      chk({tag, " res_valid"}, 64'(bus.res_valid), 64'd0);
      chk({tag, " mult_ce"}, 64'(bus.mult_ce), 64'd0);
      chk({tag, " stall"}, 64'(bus.stall), 64'd0);
   endtask

   initial begin
      bus.op_valid    = 1'b0;
      bus.md_op       = 3'd0;
      bus.op_a        = 32'd0;
      bus.op_b        = 32'd0;
      bus.load_hazard = 1'b0;
      bus.flush       = 1'b0;
      nrst            = 1'b0;
      repeat (2) cyc();
      chk_reset_outputs("reset");
      nrst = 1'b1;
      cyc();

      // multiply class: MUL_LAT+2 stall cycles, MUL_LAT+1 enable cycles
      run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT+2, MUL_LAT+1);
      chk("mul sel", 64'(bus.mult_sel), 64'd2);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT+2, MUL_LAT+1);
      chk("mulhu sel", 64'(bus.mult_sel), 64'd2);
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT+2, MUL_LAT+1);
      chk("mulh sel", 64'(bus.mult_sel), 64'd0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT+2, MUL_LAT+1);
      chk("mulhsu sel", 64'(bus.mult_sel), 64'd1);

      // divide class: 33 stall cycles
      run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
      run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
      run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);
      run_op("remu 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33, 0);
      run_op("div 20/-3", 3'd4, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 0);
      run_op("rem 20/-3", 3'd6, 32'd20, 32'hFFFF_FFFD, 32'd2, 33, 0);
      run_op("divu big/max", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);

      // special cases: single stall cycle
      run_op("divu 100/0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run_op("remu 100/0", 3'd7, 32'd100, 32'd0, 32'd100, 1, 0);
      run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
      run_op("div -5/0", 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run_op("rem -5/0", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);

      // flush in the tenth divide cycle
      bus.op_valid = 1'b1;
      bus.md_op    = 3'd4;
      bus.op_a     = 32'hFFFF_FFF9;
      bus.op_b     = 32'd2;
      #1;
      chk("flush accept stall", 64'(bus.stall), 64'd1);
      repeat (10) begin
         cyc();
         bus.op_valid = 1'b0;
      end
      #1;
      chk("flush pre stall", 64'(bus.stall), 64'd1);
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      #1;
      chk("flush stall", 64'(bus.stall), 64'd0);
      chk("flush res_valid", 64'(bus.res_valid), 64'd0);
      chk("flush res", 64'(bus.res), 64'hFFFF_FFFB);
      run_op("mul after flush", 3'd0, 32'd6, 32'd7, 32'd42, MUL_LAT+2, MUL_LAT+1);
      run_op("divu after flush", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);

      // load_hazard blocks accept in IDLE
      bus.op_valid    = 1'b1;
      bus.md_op       = 3'd0;
      bus.op_a        = 32'd3;
      bus.op_b        = 32'd3;
      bus.load_hazard = 1'b1;
      #1;
      chk("hazard idle stall", 64'(bus.stall), 64'd0);
      cyc();
      chk("hazard idle stall2", 64'(bus.stall), 64'd0);
      chk("hazard idle ce", 64'(bus.mult_ce), 64'd0);
      chk("hazard idle res_valid", 64'(bus.res_valid), 64'd0);
      bus.op_valid    = 1'b0;
      bus.load_hazard = 1'b0;

      // load_hazard holds DONE for three extra cycles
      bus.op_valid = 1'b1;
      bus.md_op    = 3'd5;
      bus.op_a     = 32'd100;
      bus.op_b     = 32'd0;
      #1;
      chk("hold accept stall", 64'(bus.stall), 64'd1);
      cyc();
      bus.op_valid    = 1'b0;
      bus.load_hazard = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold res_valid", 64'(bus.res_valid), 64'd1);
         chk("hold stall", 64'(bus.stall), 64'd0);
         cyc();
      end
      bus.load_hazard = 1'b0;
      #1;
      chk("hold res_valid last", 64'(bus.res_valid), 64'd1);
      chk("hold res", 64'(bus.res), 64'hFFFF_FFFF);
      cyc();
      chk("hold exit res_valid", 64'(bus.res_valid), 64'd0);

      // reset in the middle of MUL_WAIT
      bus.op_valid = 1'b1;
      bus.md_op    = 3'd3;
      bus.op_a     = 32'd3;
      bus.op_b     = 32'd5;
      #1;
      cyc();
      bus.op_valid = 1'b0;
      #1;
      chk("rst mid ce", 64'(bus.mult_ce), 64'd1);
      chk("rst mid sel", 64'(bus.mult_sel), 64'd2);
      chk("rst mid mult_a", 64'(bus.mult_a), 64'd3);
      nrst      = 1'b0;
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      #1;
      chk_reset_outputs("rst mid");
      nrst = 1'b1;
      cyc();
      chk("post rst res_valid", 64'(bus.res_valid), 64'd0);
      run_op("mul after rst", 3'd0, 32'd9, 32'd9, 32'd81, MUL_LAT+2, MUL_LAT+1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
